ps2_key_ctrl: RTL

PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

---
 rtl/ps2_key_ctrl_if.sv | 21 ++
 rtl/ps2_key_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_ctrl_if.sv
// CPU read port of the PS/2 keyboard controller.
// The master drives the read strobe and register select; the slave returns registered data.
interface ps2_key_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              sel;
    logic [1:0]        addr;
    logic [DATA_W-1:0] data_out;

    modport master (
        output sel,
        output addr,
        input  data_out
    );

    modport slave (
        input  sel,
        input  addr,
        output data_out
    );
endinterface

// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard receiver: frame decoder, WASD-style held-key tracker and CPU register port.
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHK_EN.
module ps2_key_ctrl #(
    parameter int TIMEOUT_CYC = 10000,
    parameter int DATA_W      = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           PS2C,
    input  logic           PS2D,
    ps2_key_ctrl_if.slave  bus,
    output logic [3:0]     keys,
    output logic           code_valid
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state, state_nxt;

    logic [1:0]    c_sync, d_sync;
    logic          c_q;
    logic          fall, din;
    logic [7:0]    sreg;
    logic [2:0]    bit_cnt;
    logic [TW-1:0] tcnt;
    logic          tmo;
    logic          shift_en, frame_ok, err_inc;
    logic          bad;
    logic          done;
    logic [7:0]    code_q;
    logic          brk, ext;
    logic          new_flag;
    logic [7:0]    last_code;
    logic [7:0]    err_cnt;
    logic          rd_new;

    always_ff @(posedge clk) begin
        if (!rst) begin
            c_sync <= 2'b11;
            d_sync <= 2'b11;
            c_q    <= 1'b1;
        end else begin
            c_sync <= {c_sync[0], PS2C};
            d_sync <= {d_sync[0], PS2D};
            c_q    <= c_sync[1];
        end
    end

    assign fall = c_q & ~c_sync[1];
    assign din  = d_sync[1];
    // A falling edge restarts the count, so it always beats a timeout
    assign tmo  = (state != IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYC));

`ifdef PS2_PARITY_CHK_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            bad <= 1'b0;
        end else if (fall && state == IDLE) begin
            bad <= 1'b0;
        end else if (fall && state == PARITY) begin
            bad <= ~^{sreg, din};
        end
    end
`else
    assign bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        frame_ok  = 1'b0;
        err_inc   = 1'b0;
        if (tmo) begin
            state_nxt = IDLE;
            err_inc   = 1'b1;
        end else if (fall) begin
            unique case (state)
                IDLE: begin
                    if (!din) state_nxt = DATA;
                end
                DATA: begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) state_nxt = PARITY;
                end
                PARITY: begin
                    state_nxt = STOP;
                end
                STOP: begin
                    state_nxt = IDLE;
                    if (din && !bad) frame_ok = 1'b1;
                    else             err_inc  = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sreg    <= 8'h00;
            bit_cnt <= 3'd0;
            tcnt    <= '0;
            done    <= 1'b0;
            code_q  <= 8'h00;
        end else begin
            done <= frame_ok;
            if (frame_ok) code_q <= sreg;
            if (tmo) begin
                sreg <= 8'h00;
            end else if (shift_en) begin
                sreg <= {din, sreg[7:1]};
            end
            if (shift_en)           bit_cnt <= bit_cnt + 3'd1;
            else if (state == IDLE) bit_cnt <= 3'd0;
            if (fall || state == IDLE) begin
                tcnt <= '0;
            end else if (tcnt != TW'(TIMEOUT_CYC)) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    // Prefix bytes only arm modifiers; everything else is a reported code
    always_ff @(posedge clk) begin
        if (!rst) begin
            brk        <= 1'b0;
            ext        <= 1'b0;
            keys       <= 4'h0;
            code_valid <= 1'b0;
            last_code  <= 8'h00;
        end else begin
            code_valid <= 1'b0;
            if (done) begin
                if (code_q == 8'hF0) begin
                    brk <= 1'b1;
                end else if (code_q == 8'hE0) begin
                    ext <= 1'b1;
                end else begin
                    code_valid <= 1'b1;
                    last_code  <= code_q;
                    brk        <= 1'b0;
                    ext        <= 1'b0;
                    if (!ext) begin
                        unique case (code_q)
                            8'h1D:   keys[0] <= ~brk;
                            8'h1B:   keys[1] <= ~brk;
                            8'h44:   keys[2] <= ~brk;
                            8'h4B:   keys[3] <= ~brk;
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    assign rd_new = bus.sel && (bus.addr == 2'd1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            new_flag <= 1'b0;
            err_cnt  <= 8'h00;
        end else begin
            if (code_valid)  new_flag <= 1'b1;
            else if (rd_new) new_flag <= 1'b0;
            if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.data_out <= '0;
        end else if (bus.sel) begin
            unique case (bus.addr)
                2'd0:    bus.data_out <= DATA_W'(keys);
                2'd1:    bus.data_out <= DATA_W'({new_flag, last_code});
                2'd2:    bus.data_out <= DATA_W'(err_cnt);
                default: bus.data_out <= '0;
            endcase
        end
    end
endmodule
